ascon_state_unloader: RTL and testbench

ASCON_STATE_UNLOADER -- requirements
Module: ascon_state_unloader

---
 rtl/ascon_state_unloader.sv | 92 +++++++++
 tb/tb_ascon_state_unloader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_state_unloader.sv
// rtl/ascon_state_unloader.sv - serializes a captured Ascon permutation state as a byte stream
// Captures S_0..S_4 on a rounds_done rising edge and streams them MSB-first with valid/ready.
module ascon_state_unloader #(
  parameter int STATE_W   = 48,
  parameter int NUM_WORDS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rounds_done,
  input  logic [STATE_W-1:0] S_0_in,
  input  logic [STATE_W-1:0] S_1_in,
  input  logic [STATE_W-1:0] S_2_in,
  input  logic [STATE_W-1:0] S_3_in,
  input  logic [STATE_W-1:0] S_4_in,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int SHADOW_W    = NUM_WORDS * STATE_W;
  localparam int TOTAL_BYTES = SHADOW_W / 8;
  localparam int CNT_W       = $clog2(TOTAL_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t              state;
  logic                rd_q;
  logic [SHADOW_W-1:0] shadow;
  logic [CNT_W-1:0]    cnt;
  logic                start;

  assign start = rounds_done & ~rd_q;

  // Byte 0 is the top byte of S_0, so index counts down from the shadow MSB.
  function automatic logic [7:0] byte_at(input logic [SHADOW_W-1:0] s,
                                         input logic [CNT_W-1:0]    idx);
    byte_at = s[SHADOW_W - 8 - 8 * int'(idx) +: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      shadow    <= '0;
      cnt       <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_q <= rounds_done;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow <= {S_0_in, S_1_in, S_2_in, S_3_in, S_4_in};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          // First SEND cycle only presents byte 0; transfers start the cycle after.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= byte_at(shadow, cnt);
          end else if (out_ready) begin
            if (cnt == LAST_IDX) begin
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              done      <= 1'b1;
              state     <= FINISH;
            end else begin
              cnt      <= cnt + 1'b1;
              out_data <= byte_at(shadow, cnt + 1'b1);
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_state_unloader.sv
// tb/tb_ascon_state_unloader.sv - self-checking bench for ascon_state_unloader
// Randomized words and backpressure checked against a byte-queue reference model.
module tb_ascon_state_unloader;

  localparam int STATE_W = 48;
  localparam int NBYTES  = 5 * STATE_W / 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rounds_done = 1'b0;
  logic [STATE_W-1:0] s_in [5];
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_state_unloader #(.STATE_W(STATE_W), .NUM_WORDS(5)) dut (
    .clk(clk), .rst_n(rst_n), .rounds_done(rounds_done),
    .S_0_in(s_in[0]), .S_1_in(s_in[1]), .S_2_in(s_in[2]), .S_3_in(s_in[3]), .S_4_in(s_in[4]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  typedef logic [7:0] byte_q_t[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_q_t model_bytes(input logic [STATE_W-1:0] w [5]);
    byte_q_t q;
    for (int i = 0; i < 5; i++)
      for (int b = 0; b < STATE_W / 8; b++)
        q.push_back(8'((w[i] >> (8 * (STATE_W / 8 - 1 - b))) & 48'hff));
    return q;
  endfunction

  task automatic set_vector();
    s_in[0] = 48'h1000808c0001;
    s_in[1] = 48'h94a4b1f09f72;
    s_in[2] = 48'h821ab7ef5039;
    s_in[3] = 48'hf6cd3f44a4c2;
    s_in[4] = 48'h03181031374d;
  endtask

  task automatic set_random();
    for (int i = 0; i < 5; i++) s_in[i] = {16'($urandom), $urandom};
  endtask

  task automatic quiesce();
    rounds_done = 1'b0;
    out_ready   = 1'b1;
    repeat (3) tick();
  endtask

  // mode 0: ready always high, 1: ready toggles 1,0,.. from first valid, 2: random ready
  task automatic collect(input int mode, output byte_q_t got, output int vcyc,
                         output int dn, output int stall_err, output int gap, output int span);
    int first_t, last_x, done_t, t;
    logic prev_stall;
    logic [7:0] prev_data;
    logic rdy;
    got = {}; vcyc = 0; dn = 0; stall_err = 0;
    first_t = -1; last_x = -1; done_t = -1; prev_stall = 1'b0; prev_data = 8'h00;
    for (t = 0; t < 400; t++) begin
      if (out_valid) begin
        vcyc++;
        if (first_t < 0) first_t = t;
      end
      if (done) begin
        dn++;
        done_t = t;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (first_t < 0) ? 1'b1 : ((t - first_t) % 2 == 0);
      else rdy = 1'($urandom_range(0, 1));
      out_ready  = rdy;
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
      if (out_valid && rdy) begin
        got.push_back(out_data);
        last_x = t;
      end
      if (done_t >= 0 && t >= done_t + 3) break;
      tick();
    end
    out_ready = 1'b1;
    gap  = (done_t >= 0 && last_x >= 0) ? done_t - last_x : -1;
    span = (done_t >= 0 && first_t >= 0) ? done_t - first_t + 1 : -1;
  endtask

  task automatic compare_frame(input string name, input byte_q_t got, input byte_q_t exp);
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, expected %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_data, out_valid, busy, done} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h valid=%b busy=%b done=%b, expected all 0",
               out_data, out_valid, busy, done);
    end
  endtask

  task automatic test_known_vector();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span;
    set_vector();
    exp = model_bytes(s_in);
    rounds_done = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_cycle1: got valid=%b busy=%b, expected valid=0 busy=1", out_valid, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      errors++;
      $display("FAIL latency_cycle2: got valid=%b data=%02h, expected valid=1 data=10", out_valid, out_data);
    end
    collect(0, got, vcyc, dn, se, gap, span);
    compare_frame("vector", got, exp);
    checks++;
    if (vcyc != NBYTES) begin
      errors++;
      $display("FAIL vector_valid_cycles: got %0d, expected %0d", vcyc, NBYTES);
    end
    checks++;
    if (dn != 1 || gap != 1) begin
      errors++;
      $display("FAIL vector_done: got count=%0d gap=%0d, expected count=1 gap=1", dn, gap);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL vector_busy_after: got %b, expected 0", busy);
    end
  endtask

  task automatic test_hold_no_retrigger();
    int seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL hold_retrigger: got %0d active cycles, expected 0", seen);
    end
    quiesce();
  endtask

  task automatic test_stall_toggle();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span;
    set_vector();
    exp = model_bytes(s_in);
    rounds_done = 1'b1;
    collect(1, got, vcyc, dn, se, gap, span);
    compare_frame("toggle", got, exp);
    checks++;
    if (se != 0) begin
      errors++;
      $display("FAIL toggle_stall_stable: got %0d unstable cycles, expected 0", se);
    end
    checks++;
    if (span != 2 * NBYTES || dn != 1) begin
      errors++;
      $display("FAIL toggle_span: got %0d cycles done=%0d, expected %0d cycles done=1", span, dn, 2 * NBYTES);
    end
    quiesce();
  endtask

  task automatic test_random_backpressure();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span;
    for (int it = 0; it < 4; it++) begin
      set_random();
      exp = model_bytes(s_in);
      rounds_done = 1'b1;
      collect(2, got, vcyc, dn, se, gap, span);
      compare_frame($sformatf("rand%0d", it), got, exp);
      checks++;
      if (se != 0 || dn != 1 || gap != 1) begin
        errors++;
        $display("FAIL rand%0d_protocol: got stall_err=%0d done=%0d gap=%0d, expected 0/1/1", it, se, dn, gap);
      end
      quiesce();
    end
  endtask

  task automatic test_shadow_isolation();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span;
    set_random();
    exp = model_bytes(s_in);
    rounds_done = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) s_in[i] = '1;
    collect(0, got, vcyc, dn, se, gap, span);
    compare_frame("shadow", got, exp);
    quiesce();
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span, guard;
    int dn_seen = 0;
    set_vector();
    exp = model_bytes(s_in);
    rounds_done = 1'b1;
    guard = 0;
    while (!(out_valid && out_data == 8'h10) && guard < 10) begin
      tick();
      guard++;
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, busy, done} !== 11'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got data=%02h valid=%b busy=%b done=%b, expected all 0",
               out_data, out_valid, busy, done);
    end
    repeat (3) begin
      tick();
      if (done) dn_seen++;
    end
    rst_n = 1'b1;
    collect(0, got, vcyc, dn, se, gap, span);
    checks++;
    if (dn_seen != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d pulses, expected 0", dn_seen);
    end
    compare_frame("after_reset", got, exp);
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL after_reset_done: got %0d, expected 1", dn);
    end
    quiesce();
  endtask

  task automatic test_second_edge_ignored();
    byte_q_t exp, got;
    int vcyc, dn, se, gap, span;
    int extra = 0;
    set_random();
    exp = model_bytes(s_in);
    rounds_done = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    rounds_done = 1'b0;
    tick();
    set_random();
    rounds_done = 1'b1;
    tick();
    collect(0, got, vcyc, dn, se, gap, span);
    compare_frame("second_edge", got, exp);
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) extra++;
      tick();
    end
    checks++;
    if (extra != 0 || dn != 1) begin
      errors++;
      $display("FAIL second_edge_single: got extra=%0d done=%0d, expected 0/1", extra, dn);
    end
    quiesce();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) s_in[i] = '0;
    #1;
    test_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_known_vector();
    test_hold_no_retrigger();
    test_stall_toggle();
    test_random_backpressure();
    test_shadow_isolation();
    test_reset_mid_frame();
    test_second_edge_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
